// File: rtl/time_set_pkg.sv
// Shared definitions for the AM/PM indicator: day constants, hour type,
// chime state encoding and hour-format helpers.
package time_set_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int NOON          = 12;

    typedef logic [7:0] hour_t;

    typedef enum logic [1:0] {
        CHIME_IDLE,
        CHIME_ON,
        CHIME_OFF
    } chime_state_e;

    function automatic logic is_valid_hour(input hour_t h);
        return h < hour_t'(HOURS_PER_DAY);
    endfunction

    function automatic logic is_pm(input hour_t h);
        return h >= hour_t'(NOON);
    endfunction

    // Midnight and noon both flash twelve times.
    function automatic logic [3:0] to_h12(input hour_t h);
        hour_t m;
        m = is_pm(h) ? (h - hour_t'(NOON)) : h;
        if (m == '0) begin
            m = hour_t'(NOON);
        end
        return m[3:0];
    endfunction

endpackage

// File: rtl/time_set_blink_timer.sv
// Half-period timer for the hour chime: counts BLINK_HALF cycles per
// phase, restarted by start, and flags the final cycle of a phase.
module time_set_blink_timer #(
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(BLINK_HALF) + 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expire = run && (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (start || !run || expire) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/time_set.sv
// AM/PM indicator LED: steady PM level, plus an optional chime that
// flashes the 12-hour value each time the sampled hour changes.
module time_set
    import time_set_pkg::*;
#(
    parameter int BLINK_HALF = 25_000_000,
    parameter bit CHIME_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] curHour,
    output logic       time_light
);

    hour_t        hour_q, hour_d;
    logic         armed_q, armed_d;
    logic         change_q, change_d;
    chime_state_e state_q, state_d;
    logic [3:0]   blinks_q, blinks_d;
    logic         time_light_q, time_light_d;

    logic         hour_valid;
    logic         pm;
    logic [3:0]   h12;
    logic         timer_start;
    logic         timer_expire;

    // Out-of-range hours are dropped entirely; the first good sample only arms.
    always_comb begin
        hour_valid = is_valid_hour(curHour);
        hour_d     = hour_valid ? curHour : hour_q;
        armed_d    = armed_q | hour_valid;
        change_d   = CHIME_EN && hour_valid && armed_q && (curHour != hour_q);
    end

    assign pm  = is_pm(hour_q);
    assign h12 = to_h12(hour_q);

    // A pending hour change always wins, restarting any chime in progress.
    always_comb begin
        state_d     = state_q;
        blinks_d    = blinks_q;
        timer_start = 1'b0;
        if (change_q) begin
            state_d     = CHIME_ON;
            blinks_d    = h12;
            timer_start = 1'b1;
        end else begin
            case (state_q)
                CHIME_IDLE: begin
                    state_d = CHIME_IDLE;
                end
                CHIME_ON: begin
                    if (timer_expire) begin
                        state_d     = CHIME_OFF;
                        timer_start = 1'b1;
                    end
                end
                CHIME_OFF: begin
                    if (timer_expire) begin
                        blinks_d = blinks_q - 4'd1;
                        if (blinks_q <= 4'd1) begin
                            state_d = CHIME_IDLE;
                        end else begin
                            state_d     = CHIME_ON;
                            timer_start = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = CHIME_IDLE;
                end
            endcase
        end
        time_light_d = (state_d == CHIME_ON) ? ~pm : pm;
    end

    time_set_blink_timer #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .run    (state_q != CHIME_IDLE),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q       <= '0;
            armed_q      <= 1'b0;
            change_q     <= 1'b0;
            state_q      <= CHIME_IDLE;
            blinks_q     <= '0;
            time_light_q <= 1'b0;
        end else begin
            hour_q       <= hour_d;
            armed_q      <= armed_d;
            change_q     <= change_d;
            state_q      <= state_d;
            blinks_q     <= blinks_d;
            time_light_q <= time_light_d;
        end
    end

    assign time_light = time_light_q;

endmodule

// File: tb/tb_time_set.sv
// Scoreboard bench for time_set: a timeline model of the PM level and chime
// pushes the expected LED per edge; the monitor pops and compares it.
module tb_time_set;

    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] curHour = 8'd0;
    logic       lightChime;
    logic       lightPlain;

    int    assertCount = 0;
    int    failCount   = 0;
    string phase       = "reset";

    bit expChime[$];
    bit expPlain[$];

    // Reference model state, index 0 = chime enabled, 1 = chime disabled.
    int mHour[2];
    int mArmed[2];
    int mPending[2];
    int mActive[2];
    int mStart[2];
    int mCount[2];
    int edgeNum = 0;

    time_set #(.BLINK_HALF(BH), .CHIME_EN(1'b1)) dutChime (
        .clk        (clk),
        .rst        (rst),
        .curHour    (curHour),
        .time_light (lightChime)
    );

    time_set #(.BLINK_HALF(BH), .CHIME_EN(1'b0)) dutPlain (
        .clk        (clk),
        .rst        (rst),
        .curHour    (curHour),
        .time_light (lightPlain)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic got, input logic exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int h12Of(input int h);
        int m;
        m = h % 12;
        return (m == 0) ? 12 : m;
    endfunction

    // The chime begins one edge after the hour register changes and is then a
    // fixed timeline: BH cycles inverted, BH cycles normal, repeated h12 times.
    task automatic modelStep(input int i, input bit ce, input bit r, input int cur,
                             output bit light);
        int disp;
        bit pm;
        if (r) begin
            mHour[i] = 0; mArmed[i] = 0; mPending[i] = 0; mActive[i] = 0;
            light = 1'b0;
            return;
        end
        disp = mHour[i];
        if (mPending[i] != 0) begin
            mStart[i]   = edgeNum;
            mCount[i]   = h12Of(disp);
            mActive[i]  = 1;
            mPending[i] = 0;
        end
        if (cur <= 23) begin
            if (mArmed[i] != 0 && cur != mHour[i] && ce) mPending[i] = 1;
            mHour[i]  = cur;
            mArmed[i] = 1;
        end
        pm = (disp >= 12);
        if (mActive[i] != 0 && (edgeNum - mStart[i]) < 2 * BH * mCount[i]) begin
            light = (((edgeNum - mStart[i]) / BH) % 2 == 0) ? !pm : pm;
        end else begin
            mActive[i] = 0;
            light = pm;
        end
    endtask

    always @(posedge clk) begin
        int c;
        bit r;
        bit e;
        c = int'(curHour);
        r = rst;
        edgeNum++;
        modelStep(0, 1'b1, r, c, e);
        expChime.push_back(e);
        modelStep(1, 1'b0, r, c, e);
        expPlain.push_back(e);
    end

    always @(negedge clk) begin
        if (expChime.size() > 0) checkOutput({phase, "/chime"}, lightChime, expChime.pop_front());
        if (expPlain.size() > 0) checkOutput({phase, "/plain"}, lightPlain, expPlain.pop_front());
    end

    task automatic applyStimulus(input string tag, input int hour, input int cycles);
        @(negedge clk);
        phase   = tag;
        curHour = 8'(hour);
        repeat (cycles - 1) @(negedge clk);
    endtask

    // Reset lands mid-cycle so the LED must drop without waiting for a clock edge.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput({tag, "/async_chime"}, lightChime, 1'b0);
        checkOutput({tag, "/async_plain"}, lightPlain, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        curHour = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_chime", lightChime, 1'b0);
        checkOutput("reset_plain", lightPlain, 1'b0);
        rst = 1'b0;

        applyStimulus("am_start", 0, 8);
        applyStimulus("pm13_one_blink", 13, 20);

        pulseReset("rearm");
        applyStimulus("arm_at_13", 13, 8);

        applyStimulus("arm_at_11", 11, 6);
        applyStimulus("noon_12_blinks", 12, 104);

        applyStimulus("am5", 5, 6);
        applyStimulus("invalid_30", 30, 10);
        applyStimulus("am5_again", 5, 4);

        applyStimulus("pm13", 13, 7);
        applyStimulus("pm14_mid", 14, 11);
        applyStimulus("pm15_restart", 15, 30);
        applyStimulus("pm16", 16, 5);
        applyStimulus("invalid_200", 200, 10);
        applyStimulus("pm16_hold", 16, 40);

        for (int h = 0; h < 24; h++) begin
            applyStimulus($sformatf("sweep_%0d", h), h, 5);
            if (h == 15) pulseReset("sweep_reset");
        end

        applyStimulus("after_sweep", 3, 60);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
